// File: rtl/lcd_pkg.sv
// Shared definitions for the HD44780-style LCD bus: command masks, line bases,
// blank character and the receiver FSM encoding.
package lcd_pkg;

  localparam int DATA_W = 8;

  localparam logic [DATA_W-1:0] CMD_CLEAR   = 8'h01;
  localparam logic [DATA_W-1:0] CMD_HOME    = 8'h02;
  localparam logic [DATA_W-1:0] CMD_ENTRY   = 8'h04;
  localparam logic [DATA_W-1:0] CMD_DISPCTL = 8'h08;
  localparam logic [DATA_W-1:0] CMD_SHIFT   = 8'h10;
  localparam logic [DATA_W-1:0] CMD_FUNC    = 8'h20;
  localparam logic [DATA_W-1:0] CMD_CGRAM   = 8'h40;
  localparam logic [DATA_W-1:0] CMD_DDRAM   = 8'h80;

  localparam logic [6:0] LINE1_BASE = 7'h00;
  localparam logic [6:0] LINE2_BASE = 7'h40;

  localparam logic [DATA_W-1:0] BLANK = 8'h20;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_CLEAR = 1'b1
  } state_t;

  // True when a command byte's highest set bit is the bit selected by mask.
  function automatic logic cmd_is(input logic [DATA_W-1:0] d, input logic [DATA_W-1:0] mask);
    return ((d & mask) != '0) && ((d & ~((mask << 1) - 8'd1)) == '0);
  endfunction

endpackage

// File: rtl/lcd_sync.sv
// Multi-bit synchronizer for the LCD bus plus falling-edge detection on the strobe.
module lcd_sync #(
  parameter int SYNC_STAGES = 2
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       i_en,
  input  logic       i_rs,
  input  logic       i_rw,
  input  logic [7:0] i_data,
  output logic       o_rs,
  output logic       o_rw,
  output logic [7:0] o_data,
  output logic       o_fall
);

  logic [10:0] r_sync [SYNC_STAGES];
  logic        r_en_d;
  logic [10:0] w_last;

  assign w_last = r_sync[SYNC_STAGES-1];

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int s = 0; s < SYNC_STAGES; s++) r_sync[s] <= '0;
      r_en_d <= 1'b0;
    end else begin
      r_sync[0] <= {i_en, i_rs, i_rw, i_data};
      for (int s = 1; s < SYNC_STAGES; s++) r_sync[s] <= r_sync[s-1];
      r_en_d <= w_last[10];
    end
  end

  assign o_rs   = w_last[9];
  assign o_rw   = w_last[8];
  assign o_data = w_last[7:0];
  assign o_fall = r_en_d & ~w_last[10];

endmodule

// File: rtl/lcd_receiver.sv
// LCD bus receiver: decodes driver writes into a 2x16 character shadow that can
// be read back through a registered port.
module lcd_receiver
  import lcd_pkg::*;
#(
  parameter int DEPTH       = 32,
  parameter int SYNC_STAGES = 2
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [7:0] lcd_data,
  input  logic       lcd_rs,
  input  logic       lcd_rw,
  input  logic       lcd_en,
  input  logic [4:0] rd_addr,
  output logic [7:0] rd_char,
  output logic [4:0] cursor,
  output logic       disp_on,
  output logic       busy,
  output logic       err,
  output logic       cmd_done
);

  logic       w_rs;
  logic       w_rw;
  logic [7:0] w_data;
  logic       w_fall;

  lcd_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync (
    .clk    (clk),
    .reset  (reset),
    .i_en   (lcd_en),
    .i_rs   (lcd_rs),
    .i_rw   (lcd_rw),
    .i_data (lcd_data),
    .o_rs   (w_rs),
    .o_rw   (w_rw),
    .o_data (w_data),
    .o_fall (w_fall)
  );

  state_t     r_state;
  logic [7:0] r_shadow [DEPTH];
  logic [7:0] r_rd_char;
  logic [4:0] r_cursor;
  logic [4:0] r_clr_idx;
  logic       r_id;
  logic       r_disp_on;
  logic       r_busy;
  logic       r_err;
  logic       r_cmd_done;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= ST_IDLE;
      for (int i = 0; i < DEPTH; i++) r_shadow[i] <= BLANK;
      r_rd_char  <= '0;
      r_cursor   <= '0;
      r_clr_idx  <= '0;
      r_id       <= 1'b1;
      r_disp_on  <= 1'b0;
      r_busy     <= 1'b0;
      r_err      <= 1'b0;
      r_cmd_done <= 1'b0;
    end else begin
      r_cmd_done <= 1'b0;
      r_rd_char  <= r_shadow[rd_addr];
      case (r_state)
        ST_IDLE: begin
          if (w_fall) begin
            r_cmd_done <= 1'b1;
            if (w_rw) begin
              r_err <= 1'b1;
            end else if (w_rs) begin
              r_shadow[r_cursor] <= w_data;
              r_cursor <= r_id ? r_cursor + 5'd1 : r_cursor - 5'd1;
            end else if (cmd_is(w_data, CMD_DDRAM)) begin
              // Only the first 16 cells of each line are shadowed.
              if (w_data[6:4] == LINE1_BASE[6:4])      r_cursor <= {1'b0, w_data[3:0]};
              else if (w_data[6:4] == LINE2_BASE[6:4]) r_cursor <= {1'b1, w_data[3:0]};
              else                                     r_err <= 1'b1;
            end else if (cmd_is(w_data, CMD_CGRAM)) begin
              r_err <= 1'b1;
            end else if (cmd_is(w_data, CMD_SHIFT)) begin
              if (!w_data[3]) r_cursor <= w_data[2] ? r_cursor + 5'd1 : r_cursor - 5'd1;
            end else if (cmd_is(w_data, CMD_DISPCTL)) begin
              r_disp_on <= w_data[2];
            end else if (cmd_is(w_data, CMD_ENTRY)) begin
              r_id <= w_data[1];
            end else if (cmd_is(w_data, CMD_HOME)) begin
              r_cursor <= '0;
            end else if (cmd_is(w_data, CMD_CLEAR)) begin
              // Completion is reported when the sweep ends, not here.
              r_cmd_done <= 1'b0;
              r_state    <= ST_CLEAR;
              r_busy     <= 1'b1;
              r_clr_idx  <= '0;
            end
          end
        end
        ST_CLEAR: begin
          r_shadow[r_clr_idx] <= BLANK;
          if (w_fall) r_err <= 1'b1;
          if (r_clr_idx == 5'(DEPTH - 1)) begin
            r_state    <= ST_IDLE;
            r_busy     <= 1'b0;
            r_cursor   <= '0;
            r_id       <= 1'b1;
            r_cmd_done <= 1'b1;
          end else begin
            r_clr_idx <= r_clr_idx + 5'd1;
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign rd_char  = r_rd_char;
  assign cursor   = r_cursor;
  assign disp_on  = r_disp_on;
  assign busy     = r_busy;
  assign err      = r_err;
  assign cmd_done = r_cmd_done;

endmodule

// File: tb/tb_lcd_receiver.sv
// Bench for lcd_receiver: directed and random bus transactions checked against
// a behavioural display model.
module tb_lcd_receiver;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic [7:0] lcd_data = 8'h00;
  logic       lcd_rs = 1'b0;
  logic       lcd_rw = 1'b0;
  logic       lcd_en = 1'b0;
  logic [4:0] rd_addr = 5'd0;
  logic [7:0] rd_char;
  logic [4:0] cursor;
  logic       disp_on, busy, err, cmd_done;

  always #5 clk = ~clk;

  lcd_receiver #(.DEPTH(32), .SYNC_STAGES(2)) dut (
    .clk(clk), .reset(reset), .lcd_data(lcd_data), .lcd_rs(lcd_rs), .lcd_rw(lcd_rw),
    .lcd_en(lcd_en), .rd_addr(rd_addr), .rd_char(rd_char), .cursor(cursor),
    .disp_on(disp_on), .busy(busy), .err(err), .cmd_done(cmd_done)
  );

  int n_cmp = 0;
  int n_bad = 0;

  // Display model
  int m_shadow [32];
  int m_cur;
  int m_id;
  int m_disp;
  int m_err;

  int busy_cnt, done_cnt, done_at_fall;

  task automatic chk(input string tag, input int obs, input int exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic mdl_reset();
    for (int i = 0; i < 32; i++) m_shadow[i] = 32;
    m_cur = 0; m_id = 1; m_disp = 0; m_err = 0;
  endtask

  task automatic mdl_apply(input logic rs, input logic rw, input logic [7:0] d);
    int msb;
    int a;
    if (rw) begin m_err = 1; return; end
    if (rs) begin
      m_shadow[m_cur] = d;
      m_cur = (m_cur + (m_id ? 1 : 31)) % 32;
      return;
    end
    msb = -1;
    for (int b = 0; b < 8; b++) if (d[b]) msb = b;
    case (msb)
      0: begin for (int i = 0; i < 32; i++) m_shadow[i] = 32; m_cur = 0; m_id = 1; end
      1: m_cur = 0;
      2: m_id = d[1];
      3: m_disp = d[2];
      4: if (!d[3]) m_cur = (m_cur + (d[2] ? 1 : 31)) % 32;
      6: m_err = 1;
      7: begin
        a = d & 8'h7f;
        if (a <= 15) m_cur = a;
        else if (a >= 64 && a <= 79) m_cur = 16 + a - 64;
        else m_err = 1;
      end
      default: ;
    endcase
  endtask

  task automatic strobe(input logic rs, input logic rw, input logic [7:0] d);
    @(negedge clk);
    lcd_rs = rs; lcd_rw = rw; lcd_data = d; lcd_en = 1'b1;
    repeat (3) @(negedge clk);
    lcd_en = 1'b0;
  endtask

  task automatic observe(input int cycles);
    logic prev_busy;
    busy_cnt = 0; done_cnt = 0; done_at_fall = 0; prev_busy = 1'b0;
    for (int c = 0; c < cycles; c++) begin
      @(negedge clk);
      if (busy) busy_cnt++;
      if (cmd_done) begin
        done_cnt++;
        if (prev_busy && !busy) done_at_fall = 1;
      end
      prev_busy = busy;
    end
  endtask

  task automatic check_state(input string tag);
    chk({tag, "_cursor"}, cursor, m_cur);
    chk({tag, "_disp_on"}, disp_on, m_disp);
    chk({tag, "_err"}, err, m_err);
    chk({tag, "_busy"}, busy, 0);
  endtask

  task automatic send(input string tag, input logic rs, input logic rw, input logic [7:0] d);
    logic is_clear;
    is_clear = !rw && !rs && (d == 8'h01);
    strobe(rs, rw, d);
    observe(is_clear ? 50 : 10);
    mdl_apply(rs, rw, d);
    if (is_clear) begin
      chk({tag, "_busy_cycles"}, busy_cnt, 32);
      chk({tag, "_done_at_busy_fall"}, done_at_fall, 1);
    end
    if (!rw) chk({tag, "_done_pulses"}, done_cnt, 1);
    check_state(tag);
  endtask

  task automatic check_shadow(input string tag);
    for (int i = 0; i < 32; i++) begin
      @(negedge clk);
      rd_addr = 5'(i);
      @(negedge clk);
      chk($sformatf("%s_cell%0d", tag, i), rd_char, m_shadow[i]);
    end
  endtask

  initial begin
    logic [7:0] b;
    logic rs, rw;
    int wait_cnt;

    mdl_reset();
    repeat (3) @(negedge clk);
    chk("rst_rd_char", rd_char, 0);
    chk("rst_cmd_done", cmd_done, 0);
    check_state("rst");
    reset = 1'b1;
    repeat (2) @(negedge clk);

    // Basic writes
    send("wr48", 1'b1, 1'b0, 8'h48);
    send("wr49", 1'b1, 1'b0, 8'h49);
    check_shadow("basic");

    // Line 2 addressing and wrap
    send("ddram_c0", 1'b0, 1'b0, 8'hC0);
    for (int i = 0; i < 16; i++) send("line2", 1'b1, 1'b0, 8'($urandom_range(33, 126)));
    check_shadow("line2");

    // Clear
    send("clear", 1'b0, 1'b0, 8'h01);
    check_shadow("clear");

    // Entry mode decrement, shift right
    send("entry04", 1'b0, 1'b0, 8'h04);
    send("dec_wr", 1'b1, 1'b0, 8'h5A);
    send("shift14", 1'b0, 1'b0, 8'h14);
    send("shift18", 1'b0, 1'b0, 8'h18);
    send("entry06", 1'b0, 1'b0, 8'h06);
    send("home", 1'b0, 1'b0, 8'h02);
    send("dispctl0c", 1'b0, 1'b0, 8'h0C);
    send("func38", 1'b0, 1'b0, 8'h38);
    send("cmd00", 1'b0, 1'b0, 8'h00);
    send("ddram_8f", 1'b0, 1'b0, 8'h8F);
    send("ddram_90", 1'b0, 1'b0, 8'h90);
    send("cgram", 1'b0, 1'b0, 8'h40);
    send("rw_rd", 1'b1, 1'b1, 8'h77);
    check_shadow("ctl");

    // Strobe arriving during a clear is dropped
    strobe(1'b0, 1'b0, 8'h01);
    repeat (10) @(negedge clk);
    strobe(1'b1, 1'b0, 8'h55);
    observe(50);
    mdl_apply(1'b0, 1'b0, 8'h01);
    m_err = 1;
    chk("midclr_done_pulses", done_cnt, 1);
    check_state("midclr");
    check_shadow("midclr");

    // Random traffic
    for (int t = 0; t < 60; t++) begin
      rs = 1'($urandom_range(0, 1));
      rw = ($urandom_range(0, 9) == 0);
      b  = 8'($urandom);
      if (!rs && ($urandom_range(0, 2) != 0)) b = b >> $urandom_range(1, 7);
      send($sformatf("rnd%0d", t), rs, rw, b);
      if (t % 20 == 19) check_shadow("rnd");
    end

    // Asynchronous reset in the middle of a clear
    send("pre_rst_wr", 1'b1, 1'b0, 8'h41);
    strobe(1'b0, 1'b0, 8'h01);
    wait_cnt = 0;
    while (!busy && wait_cnt < 20) begin @(negedge clk); wait_cnt++; end
    chk("rstclr_busy_seen", busy, 1);
    repeat (10) @(negedge clk);
    #2 reset = 1'b0;
    #1;
    mdl_reset();
    chk("rstclr_rd_char", rd_char, 0);
    chk("rstclr_cmd_done", cmd_done, 0);
    check_state("rstclr");
    repeat (2) @(negedge clk);
    reset = 1'b1;
    observe(40);
    chk("rstclr_no_done", done_cnt, 0);
    chk("rstclr_no_busy", busy_cnt, 0);
    check_shadow("rstclr");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
